// File: rtl/matrix_ops_pkg.sv
// rtl/matrix_ops_pkg.sv - matrix op, dispatcher status and dispatcher state types
// Widths fall back to the global defaults when global_defines.sv is compiled later.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef NUM_MATRIX_COLS_ROWS
`define NUM_MATRIX_COLS_ROWS 16
`endif

package matrix_ops_pkg;

  typedef enum logic [2:0] {
    OP_NOP       = 3'd0,
    OP_MATMUL    = 3'd1,
    OP_ADD       = 3'd2,
    OP_SUB       = 3'd3,
    OP_TRANSPOSE = 3'd4,
    OP_SCALE     = 3'd5
  } matrix_op_t;

  typedef enum logic [1:0] {
    DISP_OK         = 2'd0,
    DISP_ENGINE_ERR = 2'd1,
    DISP_TIMEOUT    = 2'd2,
    DISP_BAD_DIM    = 2'd3
  } disp_status_t;

  typedef enum logic [2:0] {
    DS_IDLE,
    DS_CHECK,
    DS_CFG,
    DS_CFG_GAP,
    DS_START,
    DS_WAIT_DONE,
    DS_RESPOND
  } disp_state_t;

  function automatic logic dims_illegal(
    input logic [`NUM_MATRIX_COLS_ROWS-1:0] rows,
    input logic [`NUM_MATRIX_COLS_ROWS-1:0] cols,
    input logic [`NUM_MATRIX_COLS_ROWS-1:0] max_dim
  );
    return (rows == '0) || (cols == '0) || (rows > max_dim) || (cols > max_dim);
  endfunction

endpackage

// File: rtl/disp_watchdog.sv
// rtl/disp_watchdog.sv - loadable up-counter with clear/enable and terminal-count flag
module disp_watchdog #(
  parameter int            W        = 10,
  parameter logic [W-1:0]  TERMINAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         enable,
  output logic [W-1:0] count,
  output logic         terminal
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = (count == TERMINAL);

endmodule

// File: rtl/global_defines.sv
// rtl/global_defines.sv - shared widths for the matrix engine command/config interface
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef NUM_MATRIX_COLS_ROWS
`define NUM_MATRIX_COLS_ROWS 16
`endif

// File: rtl/matrix_op_dispatcher.sv
// rtl/matrix_op_dispatcher.sv - one-at-a-time matrix command dispatcher with watchdog
// Optional config reuse across identical dimensions: DISP_CONFIG_CACHE_EN.
module matrix_op_dispatcher
  import matrix_ops_pkg::*;
#(
  parameter logic [`NUM_MATRIX_COLS_ROWS-1:0] MAX_DIM        = 16'd64,
  parameter int                               TIMEOUT_CYCLES = 1024,
  parameter int                               LAT_W          = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cmd_valid,
  output logic                             cmd_ready,
  input  matrix_op_t                       cmd_op,
  input  logic [`NUM_MATRIX_COLS_ROWS-1:0] cmd_rows,
  input  logic [`NUM_MATRIX_COLS_ROWS-1:0] cmd_cols,
  output matrix_op_t                       operation,
  output logic                             start_operation,
  output logic                             config_valid,
  output logic [`INSTRUCTION_WIDTH-1:0]    config_data,
  input  logic                             operation_done,
  input  logic                             operation_error,
  input  logic                             busy,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output disp_status_t                     rsp_status,
  output logic [LAT_W-1:0]                 rsp_latency
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES);

  disp_state_t                      state_q, state_d;
  disp_status_t                     status_q, status_d;
  matrix_op_t                       op_q;
  logic [`NUM_MATRIX_COLS_ROWS-1:0] rows_q, cols_q;
  logic [LAT_W-1:0]                 lat_q;
  logic                             wd_clear, wd_enable, wd_terminal;
  logic [TO_W-1:0]                  wd_count_unused;
  logic                             busy_unused;
  logic                             cache_hit;

  assign busy_unused = busy;

  disp_watchdog #(
    .W        (TO_W),
    .TERMINAL (TO_W'(TIMEOUT_CYCLES - 1))
  ) u_watchdog (
    .clk        (clk),
    .rst        (rst),
    .clear      (wd_clear),
    .load       (1'b0),
    .load_value ('0),
    .enable     (wd_enable),
    .count      (wd_count_unused),
    .terminal   (wd_terminal)
  );

`ifdef DISP_CONFIG_CACHE_EN
  logic [`NUM_MATRIX_COLS_ROWS-1:0] last_rows, last_cols;
  logic                             cfg_cached;

  // Any failed run leaves the engine config in doubt, so the cache is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_cached <= 1'b0;
      last_rows  <= '0;
      last_cols  <= '0;
    end else if (state_q == DS_CFG) begin
      cfg_cached <= 1'b1;
      last_rows  <= rows_q;
      last_cols  <= cols_q;
    end else if (state_q == DS_WAIT_DONE && state_d == DS_RESPOND && status_d != DISP_OK) begin
      cfg_cached <= 1'b0;
    end
  end

  assign cache_hit = cfg_cached && (rows_q == last_rows) && (cols_q == last_cols);
`else
  assign cache_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DS_IDLE;
      status_q <= DISP_OK;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    status_d        = status_q;
    cmd_ready       = 1'b0;
    config_valid    = 1'b0;
    start_operation = 1'b0;
    rsp_valid       = 1'b0;
    wd_clear        = 1'b0;
    wd_enable       = 1'b0;
    case (state_q)
      DS_IDLE: begin
        cmd_ready = !rst;
        if (cmd_valid && cmd_ready) state_d = DS_CHECK;
      end
      DS_CHECK: begin
        if (dims_illegal(rows_q, cols_q, MAX_DIM)) begin
          status_d = DISP_BAD_DIM;
          state_d  = DS_RESPOND;
        end else if (cache_hit) begin
          state_d = DS_START;
        end else begin
          state_d = DS_CFG;
        end
      end
      DS_CFG: begin
        config_valid = 1'b1;
        state_d      = DS_CFG_GAP;
      end
      DS_CFG_GAP: state_d = DS_START;
      DS_START: begin
        start_operation = 1'b1;
        wd_clear        = 1'b1;
        state_d         = DS_WAIT_DONE;
      end
      DS_WAIT_DONE: begin
        if (operation_error) begin
          status_d = DISP_ENGINE_ERR;
          state_d  = DS_RESPOND;
        end else if (operation_done) begin
          status_d = DISP_OK;
          state_d  = DS_RESPOND;
        end else if (wd_terminal) begin
          status_d = DISP_TIMEOUT;
          state_d  = DS_RESPOND;
        end else begin
          wd_enable = 1'b1;
        end
      end
      DS_RESPOND: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = DS_IDLE;
      end
      default: state_d = DS_IDLE;
    endcase
  end

  // Latency runs from CHECK up to the edge entering RESPOND, then holds for the response.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_NOP;
      rows_q <= '0;
      cols_q <= '0;
      lat_q  <= '0;
    end else if (state_q == DS_IDLE) begin
      if (cmd_valid && cmd_ready) begin
        op_q   <= cmd_op;
        rows_q <= cmd_rows;
        cols_q <= cmd_cols;
        lat_q  <= '0;
      end
    end else if (state_q != DS_RESPOND && lat_q != '1) begin
      lat_q <= lat_q + 1'b1;
    end
  end

  assign operation   = op_q;
  assign config_data = config_valid ? `INSTRUCTION_WIDTH'({rows_q, cols_q}) : '0;
  assign rsp_status  = status_q;
  assign rsp_latency = lat_q;

endmodule

// File: tb/tb_matrix_op_dispatcher.sv
// tb/tb_matrix_op_dispatcher.sv - randomized and directed bench for matrix_op_dispatcher
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 32
`endif
`ifndef NUM_MATRIX_COLS_ROWS
`define NUM_MATRIX_COLS_ROWS 16
`endif

module tb_matrix_op_dispatcher;
  import matrix_ops_pkg::*;

  localparam int TO  = 16;
  localparam int MAXD = 64;

  logic                             clk = 1'b0;
  logic                             rst;
  logic                             cmd_valid;
  logic                             cmd_ready;
  matrix_op_t                       cmd_op;
  logic [`NUM_MATRIX_COLS_ROWS-1:0] cmd_rows, cmd_cols;
  matrix_op_t                       operation;
  logic                             start_operation, config_valid;
  logic [`INSTRUCTION_WIDTH-1:0]    config_data;
  logic                             operation_done, operation_error, busy;
  logic                             rsp_valid, rsp_ready;
  disp_status_t                     rsp_status;
  logic [15:0]                      rsp_latency;

  int vectors = 0;
  int miscompares = 0;

  bit          cached_m = 0;
  logic [15:0] last_r_m = '0, last_c_m = '0;

  always #5 clk = ~clk;

  matrix_op_dispatcher #(
    .MAX_DIM        (16'd64),
    .TIMEOUT_CYCLES (TO),
    .LAT_W          (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_rows        (cmd_rows),
    .cmd_cols        (cmd_cols),
    .operation       (operation),
    .start_operation (start_operation),
    .config_valid    (config_valid),
    .config_data     (config_data),
    .operation_done  (operation_done),
    .operation_error (operation_error),
    .busy            (busy),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_status      (rsp_status),
    .rsp_latency     (rsp_latency)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode: 0 done, 1 error, 2 done+error together, 3 engine silent; dly = WAIT cycle of the pulse
  task automatic run_cmd(input matrix_op_t op, input logic [15:0] r, input logic [15:0] c,
                         input int mode, input int dly, input int hold);
    bit          bad, hit, started, got;
    int          exp_wait, exp_lat, cfg_n, start_n, k;
    logic [1:0]  exp_st;
    logic [31:0] cfg_d;
    bad = (r == 0) || (c == 0) || (r > MAXD) || (c > MAXD);
`ifdef DISP_CONFIG_CACHE_EN
    hit = !bad && cached_m && (r == last_r_m) && (c == last_c_m);
`else
    hit = 0;
`endif
    exp_wait = (mode == 3) ? TO : dly;
    exp_st   = bad ? 2'd3 : (mode == 1 || mode == 2) ? 2'd1 : (mode == 3) ? 2'd2 : 2'd0;
    exp_lat  = bad ? 1 : (hit ? 2 : 4) + exp_wait;
    started = 0; got = 0; cfg_n = 0; start_n = 0; k = 0; cfg_d = '0;

    cmd_valid = 1'b1; cmd_op = op; cmd_rows = r; cmd_cols = c;
    check("cmd_ready_idle", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int cyc = 0; cyc < 200 && !got; cyc++) begin
      if (rsp_valid) begin
        got = 1;
      end else begin
        if (config_valid) begin cfg_n++; cfg_d = config_data; end
        if (start_operation) begin
          start_n++; started = 1; k = 0;
          check("operation_at_start", operation, op);
        end else if (started) begin
          k++;
        end
        operation_done  = started && (k == dly) && (mode == 0 || mode == 2);
        operation_error = started && (k == dly) && (mode == 1 || mode == 2);
        busy            = started;
        @(negedge clk);
      end
    end
    operation_done = 1'b0; operation_error = 1'b0; busy = 1'b0;

    check("rsp_seen", got, 1);
    check("rsp_status", rsp_status, exp_st);
    check("rsp_latency", rsp_latency, exp_lat);
    check("config_pulses", cfg_n, (bad || hit) ? 0 : 1);
    check("start_pulses", start_n, bad ? 0 : 1);
    if (cfg_n > 0) check("config_data", cfg_d, {r, c});
    if (!bad) check("wait_cycles", k, exp_wait);

    if (!bad && !hit) begin cached_m = 1; last_r_m = r; last_c_m = c; end
    if (exp_st == 2'd1 || exp_st == 2'd2) cached_m = 0;

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", rsp_valid, 1);
      check("hold_status", rsp_status, exp_st);
      check("hold_latency", rsp_latency, exp_lat);
      check("hold_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", rsp_valid, 0);
    check("post_cmd_ready", cmd_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_time_limit: observed no finish expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    bit got_start;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_rows = '0; cmd_cols = '0;
    operation_done = 1'b0; operation_error = 1'b0; busy = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_cmd_ready", cmd_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_start", start_operation, 0);
    check("reset_cfg_valid", config_valid, 0);
    check("reset_cfg_data", config_data, 0);
    check("reset_status", rsp_status, 0);
    check("reset_latency", rsp_latency, 0);
    check("reset_operation", operation, 0);
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_cmd_ready", cmd_ready, 1);

    // stray engine pulses while idle must be ignored
    operation_done = 1'b1; operation_error = 1'b1;
    @(negedge clk);
    operation_done = 1'b0; operation_error = 1'b0;
    check("stray_rsp_valid", rsp_valid, 0);
    check("stray_cmd_ready", cmd_ready, 1);

    run_cmd(OP_MATMUL,    16'd4,  16'd8,  0, 3, 0);
    run_cmd(OP_ADD,       16'd0,  16'd5,  0, 1, 0);
    run_cmd(OP_SUB,       16'd65, 16'd1,  0, 1, 0);
    run_cmd(OP_SCALE,     16'd64, 16'd64, 0, 1, 0);
    run_cmd(OP_TRANSPOSE, 16'd3,  16'd3,  3, 0, 0);
    run_cmd(OP_MATMUL,    16'd2,  16'd2,  2, 2, 0);
    run_cmd(OP_ADD,       16'd5,  16'd6,  0, 2, 10);

    // reset during WAIT_DONE drops the in-flight command
    cmd_valid = 1'b1; cmd_op = OP_MATMUL; cmd_rows = 16'd9; cmd_cols = 16'd9;
    @(negedge clk);
    cmd_valid = 1'b0;
    got_start = 0;
    for (int cyc = 0; cyc < 20 && !got_start; cyc++) begin
      if (start_operation) got_start = 1;
      @(negedge clk);
    end
    check("abort_started", got_start, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cmd_ready_in_reset", cmd_ready, 0);
    check("abort_rsp_valid_in_reset", rsp_valid, 0);
    rst = 1'b0;
    cached_m = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      operation_done = (cyc == 1);
      @(negedge clk);
      check("abort_no_rsp", rsp_valid, 0);
      check("abort_no_start", start_operation, 0);
      check("abort_no_cfg", config_valid, 0);
    end
    operation_done = 1'b0;
    run_cmd(OP_MATMUL, 16'd7, 16'd7, 0, 3, 0);
    run_cmd(OP_MATMUL, 16'd7, 16'd7, 0, 3, 0);

    for (int i = 0; i < 30; i++) begin
      matrix_op_t  op;
      logic [15:0] r, c;
      int          mode;
      op   = matrix_op_t'($urandom_range(0, 5));
      r    = ($urandom_range(0, 3) == 0) ? 16'(last_r_m) : 16'($urandom_range(0, 70));
      c    = ($urandom_range(0, 3) == 0) ? 16'(last_c_m) : 16'($urandom_range(0, 70));
      mode = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
      run_cmd(op, r, c, mode, int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
